rgb_color_fader: RTL and testbench



---
 rtl/rgb_color_fader.sv | 140 ++++++++++++++
 tb/tb_rgb_color_fader.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_color_fader.sv
// rgb_color_fader: ramps an RGB colour from its present value toward a loaded
// target in fixed steps, one step every (rate+1) rising edges of the PWM sync
// strobe. Optional macro RGB_FADER_GAMMA_EN maps each registered output
// through (c*c + c) >> 8 while all fade arithmetic stays linear.
module rgb_color_fader #(
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync_i,
  input  logic              load_i,
  input  logic [7:0]        rtarget_i,
  input  logic [7:0]        gtarget_i,
  input  logic [7:0]        btarget_i,
  input  logic [7:0]        step_i,
  input  logic [RATE_W-1:0] rate_i,
  output logic [7:0]        rcolor_o,
  output logic [7:0]        gcolor_o,
  output logic [7:0]        bcolor_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic {IDLE, FADE} state_t;

  // Channel index 2 = red, 1 = green, 0 = blue throughout.
  state_t            state, state_next;
  logic [2:0][7:0]   cur, cur_next;
  logic [2:0][7:0]   tgt, tgt_next;
  logic [2:0][7:0]   tgt_in;
  logic [2:0][7:0]   col_q, col_next;
  logic [7:0]        step_r, step_next;
  logic [RATE_W-1:0] rate_r, rate_next;
  logic [RATE_W-1:0] presc, presc_next;
  logic              sync_q;
  logic              sync_edge;
  logic              done_next;

  // Move one channel toward its target by at most step, never past it.
  function automatic logic [7:0] approach(input logic [7:0] c,
                                          input logic [7:0] t,
                                          input logic [7:0] s);
    logic [7:0] diff;
    logic [7:0] res;
    res = c;
    if (t > c) begin
      diff = t - c;
      res  = (s < diff) ? c + s : t;
    end else if (t < c) begin
      diff = c - t;
      res  = (s < diff) ? c - s : t;
    end
    return res;
  endfunction

  // Output shaping: square-law gamma when enabled, identity otherwise.
  function automatic logic [7:0] shape(input logic [7:0] c);
`ifdef RGB_FADER_GAMMA_EN
    logic [15:0] sq;
    sq = 16'(c) * 16'(c) + 16'(c);
    return sq[15:8];
`else
    return c;
`endif
  endfunction

  assign tgt_in    = {rtarget_i, gtarget_i, btarget_i};
  assign sync_edge = sync_i & ~sync_q;
  assign busy_o    = (state == FADE);
  assign rcolor_o  = col_q[2];
  assign gcolor_o  = col_q[1];
  assign bcolor_o  = col_q[0];

  // Next-state logic: a load always wins; otherwise a prescaled sync tick
  // advances every channel and retires the fade once all targets are met.
  always_comb begin
    state_next = state;
    cur_next   = cur;
    tgt_next   = tgt;
    step_next  = step_r;
    rate_next  = rate_r;
    presc_next = presc;
    done_next  = 1'b0;
    if (load_i) begin
      tgt_next   = tgt_in;
      step_next  = (step_i == 8'd0) ? 8'd1 : step_i;
      rate_next  = rate_i;
      presc_next = '0;
      if (tgt_in == cur) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end else begin
        state_next = FADE;
      end
    end else if (state == FADE && sync_edge) begin
      if (presc == rate_r) begin
        presc_next = '0;
        for (int i = 0; i < 3; i++) begin
          cur_next[i] = approach(cur[i], tgt[i], step_r);
        end
        if (cur_next == tgt) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end else begin
        presc_next = presc + 1'b1;
      end
    end
    for (int i = 0; i < 3; i++) begin
      col_next[i] = shape(cur_next[i]);
    end
  end

  // State register; outputs are taken from next-state values so the colour
  // appears one cycle after its tick whether or not gamma is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cur    <= '0;
      tgt    <= '0;
      col_q  <= '0;
      step_r <= 8'd1;
      rate_r <= '0;
      presc  <= '0;
      sync_q <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state  <= state_next;
      cur    <= cur_next;
      tgt    <= tgt_next;
      col_q  <= col_next;
      step_r <= step_next;
      rate_r <= rate_next;
      presc  <= presc_next;
      sync_q <= sync_i;
      done_o <= done_next;
    end
  end

endmodule

// File: tb/tb_rgb_color_fader.sv
// Bench for rgb_color_fader: directed scenarios plus randomized targets, steps,
// rates and sync pulse shapes, compared against a per-sync-edge colour model.
`timescale 1ns/1ps
module tb_rgb_color_fader;

  logic       clk = 1'b0;
  logic       rst;
  logic       sync_i;
  logic       load_i;
  logic [7:0] rtarget_i;
  logic [7:0] gtarget_i;
  logic [7:0] btarget_i;
  logic [7:0] step_i;
  logic [7:0] rate_i;
  logic [7:0] rcolor_o;
  logic [7:0] gcolor_o;
  logic [7:0] bcolor_o;
  logic       busy_o;
  logic       done_o;

  int checks = 0;
  int passed = 0;

  // Reference model state, index 0 = red, 1 = green, 2 = blue.
  int m_cur[3];
  int m_tgt[3];
  int m_step;
  int m_rate;
  int m_cnt;
  bit m_busy;
  bit m_done;

  logic [23:0] obs_col;
  logic [1:0]  obs_stat;
  int          extra_done;
  int          extra_change;

  rgb_color_fader #(.RATE_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sync_i    (sync_i),
    .load_i    (load_i),
    .rtarget_i (rtarget_i),
    .gtarget_i (gtarget_i),
    .btarget_i (btarget_i),
    .step_i    (step_i),
    .rate_i    (rate_i),
    .rcolor_o  (rcolor_o),
    .gcolor_o  (gcolor_o),
    .bcolor_o  (bcolor_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int shape(input int c);
`ifdef RGB_FADER_GAMMA_EN
    return (c * c + c) / 256;
`else
    return c;
`endif
  endfunction

  function automatic logic [23:0] exp_col();
    logic [23:0] v;
    v[23:16] = 8'(shape(m_cur[0]));
    v[15:8]  = 8'(shape(m_cur[1]));
    v[7:0]   = 8'(shape(m_cur[2]));
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cur[i] = 0;
      m_tgt[i] = 0;
    end
    m_step = 1;
    m_rate = 0;
    m_cnt  = 0;
    m_busy = 1'b0;
    m_done = 1'b0;
  endfunction

  function automatic void model_load(input int r, input int g, input int b,
                                     input int s, input int rt);
    m_tgt[0] = r;
    m_tgt[1] = g;
    m_tgt[2] = b;
    m_step   = (s == 0) ? 1 : s;
    m_rate   = rt;
    m_cnt    = 0;
    if (m_tgt[0] == m_cur[0] && m_tgt[1] == m_cur[1] && m_tgt[2] == m_cur[2]) begin
      m_busy = 1'b0;
      m_done = 1'b1;
    end else begin
      m_busy = 1'b1;
      m_done = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    int d;
    m_done = 1'b0;
    if (m_busy) begin
      if (m_cnt == m_rate) begin
        m_cnt = 0;
        for (int i = 0; i < 3; i++) begin
          d = m_tgt[i] - m_cur[i];
          if (d > 0) m_cur[i] += (m_step < d) ? m_step : d;
          else if (d < 0) m_cur[i] -= (m_step < -d) ? m_step : -d;
        end
        if (m_tgt[0] == m_cur[0] && m_tgt[1] == m_cur[1] && m_tgt[2] == m_cur[2]) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else begin
        m_cnt++;
      end
    end
  endfunction

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic capture();
    obs_col  = {rcolor_o, gcolor_o, bcolor_o};
    obs_stat = {busy_o, done_o};
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick_clk();
      if (done_o === 1'b1) extra_done++;
      if ({rcolor_o, gcolor_o, bcolor_o} !== obs_col) extra_change++;
    end
  endtask

  task automatic pulse_sync(input int width, input int gap);
    sync_i = 1'b1;
    tick_clk();
    model_edge();
    capture();
    idle_cycles(width - 1);
    sync_i = 1'b0;
    idle_cycles(gap);
  endtask

  task automatic do_load(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic [7:0] s, input logic [7:0] rt, input logic with_sync);
    rtarget_i = r;
    gtarget_i = g;
    btarget_i = b;
    step_i    = s;
    rate_i    = rt;
    load_i    = 1'b1;
    sync_i    = with_sync;
    tick_clk();
    load_i = 1'b0;
    sync_i = 1'b0;
    model_load(int'(r), int'(g), int'(b), int'(s), int'(rt));
    capture();
    idle_cycles(1);
  endtask

  function automatic logic [7:0] far_from(input int c);
    return (c < 128) ? 8'd230 : 8'd20;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick_clk();
    tick_clk();
    capture();
    checks++;
    if (obs_col !== 24'h0) $display("[TB] FAIL reset_colour got=%h exp=%h", obs_col, 24'h0);
    else passed++;
    checks++;
    if (obs_stat !== 2'b00) $display("[TB] FAIL reset_status got=%b exp=%b", obs_stat, 2'b00);
    else passed++;
    rst = 1'b0;
    model_reset();
    tick_clk();
  endtask

  task automatic test_ramp_up();
    int done_seen;
    extra_done   = 0;
    extra_change = 0;
    do_load(8'd255, 8'd0, 8'd128, 8'd16, 8'd0, 1'b0);
    done_seen = int'(obs_stat[0]);
    checks++;
    if (obs_stat !== 2'b10) $display("[TB] FAIL ramp_load_status got=%b exp=%b", obs_stat, 2'b10);
    else passed++;
    for (int k = 1; k <= 16; k++) begin
      pulse_sync(1, 255);
      done_seen += int'(obs_stat[0]);
      checks++;
      if (obs_col !== exp_col()) $display("[TB] FAIL ramp_colour tick=%0d got=%h exp=%h", k, obs_col, exp_col());
      else passed++;
      checks++;
      if (obs_stat !== {m_busy, m_done}) $display("[TB] FAIL ramp_status tick=%0d got=%b exp=%b", k, obs_stat, {m_busy, m_done});
      else passed++;
      if (k == 8) begin
        checks++;
        if (obs_col[7:0] !== 8'(shape(128))) $display("[TB] FAIL ramp_blue_tick8 got=%0d exp=%0d", obs_col[7:0], shape(128));
        else passed++;
      end
    end
    checks++;
    if (obs_stat !== 2'b01) $display("[TB] FAIL ramp_final_status got=%b exp=%b", obs_stat, 2'b01);
    else passed++;
    checks++;
    if (obs_col[23:16] !== 8'(shape(255)) || obs_col[15:8] !== 8'd0)
      $display("[TB] FAIL ramp_final_rg got=%h exp=%h", obs_col[23:8], {8'(shape(255)), 8'd0});
    else passed++;
    checks++;
    if (done_seen + extra_done != 1) $display("[TB] FAIL ramp_done_count got=%0d exp=1", done_seen + extra_done);
    else passed++;
    checks++;
    if (extra_change != 0) $display("[TB] FAIL ramp_between_ticks changes=%0d exp=0", extra_change);
    else passed++;
  endtask

  task automatic test_step_zero();
    int done_seen;
    extra_done = 0;
    do_load(8'd250, 8'd10, 8'd128, 8'd0, 8'd0, 1'b0);
    done_seen = int'(obs_stat[0]);
    for (int k = 1; k <= 10; k++) begin
      pulse_sync(1, 15);
      done_seen += int'(obs_stat[0]);
      checks++;
      if (obs_col !== exp_col()) $display("[TB] FAIL step0_colour tick=%0d got=%h exp=%h", k, obs_col, exp_col());
      else passed++;
    end
    checks++;
    if (obs_col !== {8'(shape(250)), 8'(shape(10)), 8'(shape(128))})
      $display("[TB] FAIL step0_final got=%h exp=%h", obs_col, {8'(shape(250)), 8'(shape(10)), 8'(shape(128))});
    else passed++;
    checks++;
    if (obs_stat !== 2'b01 || done_seen + extra_done != 1)
      $display("[TB] FAIL step0_done status=%b dones=%0d exp=01/1", obs_stat, done_seen + extra_done);
    else passed++;
  endtask

  task automatic test_rate();
    logic [23:0] prev;
    int p;
    extra_change = 0;
    do_load(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(1, 40)), 8'd3, 1'b0);
    p = 0;
    while (m_busy && p < 1500) begin
      p++;
      prev = obs_col;
      pulse_sync(3, 4);
      checks++;
      if (obs_col !== exp_col()) $display("[TB] FAIL rate_colour edge=%0d got=%h exp=%h", p, obs_col, exp_col());
      else passed++;
      checks++;
      if (obs_stat !== {m_busy, m_done}) $display("[TB] FAIL rate_status edge=%0d got=%b exp=%b", p, obs_stat, {m_busy, m_done});
      else passed++;
      if (p % 4 != 0) begin
        checks++;
        if (obs_col !== prev) $display("[TB] FAIL rate_hold edge=%0d got=%h exp=%h", p, obs_col, prev);
        else passed++;
      end
    end
    checks++;
    if (m_busy) $display("[TB] FAIL rate_timeout edges=%0d exp=done", p);
    else passed++;
    checks++;
    if (extra_change != 0) $display("[TB] FAIL rate_long_sync changes=%0d exp=0", extra_change);
    else passed++;
  endtask

  task automatic test_retarget_tick();
    logic [23:0] held;
    int p;
    do_load(far_from(m_cur[0]), far_from(m_cur[1]), far_from(m_cur[2]), 8'd7, 8'd1, 1'b0);
    repeat (5) pulse_sync(1, 3);
    checks++;
    if (obs_col !== exp_col()) $display("[TB] FAIL retarget_pre got=%h exp=%h", obs_col, exp_col());
    else passed++;
    held = obs_col;
    do_load(8'd0, 8'd0, 8'd0, 8'd9, 8'd0, 1'b1);
    checks++;
    if (obs_col !== held) $display("[TB] FAIL retarget_hold got=%h exp=%h", obs_col, held);
    else passed++;
    checks++;
    if (obs_stat !== 2'b10) $display("[TB] FAIL retarget_status got=%b exp=%b", obs_stat, 2'b10);
    else passed++;
    p = 0;
    while (m_busy && p < 500) begin
      p++;
      pulse_sync(1, 2);
      checks++;
      if (obs_col !== exp_col()) $display("[TB] FAIL retarget_colour edge=%0d got=%h exp=%h", p, obs_col, exp_col());
      else passed++;
    end
    checks++;
    if (m_busy || obs_col !== 24'h0) $display("[TB] FAIL retarget_final got=%h exp=%h", obs_col, 24'h0);
    else passed++;
  endtask

  task automatic test_equal_target();
    extra_done = 0;
    do_load(8'(m_cur[0]), 8'(m_cur[1]), 8'(m_cur[2]), 8'($urandom_range(0, 255)), 8'd2, 1'b0);
    checks++;
    if (obs_stat !== 2'b01) $display("[TB] FAIL equal_load_status got=%b exp=%b", obs_stat, 2'b01);
    else passed++;
    capture();
    checks++;
    if (obs_stat !== 2'b00 || extra_done != 0)
      $display("[TB] FAIL equal_after status=%b extra_dones=%0d exp=00/0", obs_stat, extra_done);
    else passed++;
  endtask

  task automatic test_reset_midfade();
    int done_seen;
    int p;
    do_load(far_from(m_cur[0]), far_from(m_cur[1]), far_from(m_cur[2]), 8'd3, 8'd0, 1'b0);
    repeat (3) pulse_sync(1, 2);
    extra_done = 0;
    rst = 1'b1;
    tick_clk();
    capture();
    rst = 1'b0;
    model_reset();
    checks++;
    if (obs_col !== 24'h0) $display("[TB] FAIL midreset_colour got=%h exp=%h", obs_col, 24'h0);
    else passed++;
    checks++;
    if (obs_stat !== 2'b00) $display("[TB] FAIL midreset_status got=%b exp=%b", obs_stat, 2'b00);
    else passed++;
    idle_cycles(6);
    checks++;
    if (extra_done != 0) $display("[TB] FAIL midreset_no_done got=%0d exp=0", extra_done);
    else passed++;
    do_load(8'd40, 8'd80, 8'd120, 8'd20, 8'd1, 1'b0);
    done_seen = int'(obs_stat[0]);
    p = 0;
    while (m_busy && p < 200) begin
      p++;
      pulse_sync(2, 2);
      done_seen += int'(obs_stat[0]);
      checks++;
      if (obs_col !== exp_col()) $display("[TB] FAIL postreset_colour edge=%0d got=%h exp=%h", p, obs_col, exp_col());
      else passed++;
    end
    checks++;
    if (m_busy || done_seen + extra_done != 1)
      $display("[TB] FAIL postreset_done busy=%0b dones=%0d exp=0/1", m_busy, done_seen + extra_done);
    else passed++;
  endtask

  task automatic test_random();
    int done_seen;
    int n;
    int reloads;
    for (int round = 0; round < 4; round++) begin
      extra_done   = 0;
      extra_change = 0;
      reloads      = 0;
      do_load(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 2)), 1'b0);
      done_seen = int'(obs_stat[0]);
      n = 0;
      while (m_busy && n < 4000) begin
        n++;
        if (reloads < 2 && $urandom_range(0, 9) == 0) begin
          reloads++;
          do_load(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end else begin
          pulse_sync($urandom_range(1, 2), $urandom_range(1, 3));
        end
        done_seen += int'(obs_stat[0]);
        checks++;
        if (obs_col !== exp_col()) $display("[TB] FAIL random_colour round=%0d ev=%0d got=%h exp=%h", round, n, obs_col, exp_col());
        else passed++;
        checks++;
        if (obs_stat !== {m_busy, m_done}) $display("[TB] FAIL random_status round=%0d ev=%0d got=%b exp=%b", round, n, obs_stat, {m_busy, m_done});
        else passed++;
      end
      checks++;
      if (m_busy) $display("[TB] FAIL random_timeout round=%0d events=%0d exp=done", round, n);
      else passed++;
      checks++;
      if (done_seen + extra_done != 1 || extra_change != 0)
        $display("[TB] FAIL random_pulses round=%0d dones=%0d changes=%0d exp=1/0", round, done_seen + extra_done, extra_change);
      else passed++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    sync_i    = 1'b0;
    load_i    = 1'b0;
    rtarget_i = 8'd0;
    gtarget_i = 8'd0;
    btarget_i = 8'd0;
    step_i    = 8'd0;
    rate_i    = 8'd0;
    obs_col   = 24'h0;
    obs_stat  = 2'b00;
    extra_done   = 0;
    extra_change = 0;
    model_reset();
    test_reset();
    test_ramp_up();
    test_step_zero();
    test_rate();
    test_retarget_tick();
    test_equal_target();
    test_reset_midfade();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
